axi_read_slave: RTL and testbench
=================================

// Module: axi_read_slave
// PURPOSE
//  AXI4 read-channel responder (AR + R). It is the read-direction counterpart of the write master/slave pair.
//  Accepts one read burst at a time and computes per-beat addresses for FIXED, INCR and WRAP bursts.
//  Fetches each beat from a 1-cycle-latency synchronous memory port and returns it on R with RID, RRESP and RLAST.
//  Sits between the read-master model and the local memory in the composed read path.
// PARAMETERS
//  IDW  12  ID width (ARID/RID)
//  AW   32  address width
//  DW   64  data width (bits); DW/8 = bytes per beat, power of two
// PORTS
//  clk            in   1      global clock, rising edge
//  resetn         in   1      asynchronous active-low reset
//  s_axi_arid     in   IDW    read address ID
//  s_axi_araddr   in   AW     start address
//  s_axi_arlen    in   8      beats-1
//  s_axi_arsize   in   3      log2(bytes per beat)
//  s_axi_arburst  in   2      00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  s_axi_arvalid  in   1      address valid
//  s_axi_arready  out  1      address ready
//  s_axi_rid      out  IDW    = latched ARID
//  s_axi_rdata    out  DW     beat data
//  s_axi_rresp    out  2      00 OKAY, 10 SLVERR
//  s_axi_rlast    out  1      final beat
//  s_axi_rvalid   out  1      beat valid
//  s_axi_rready   in   1      master accepts beat
//  mem_rd_en      out  1      one-cycle memory read strobe
//  mem_rd_addr    out  AW     memory byte address (valid with mem_rd_en)
//  mem_rd_data    in   DW     memory data, valid cycle after mem_rd_en
// BEHAVIOUR
//  Reset values: arready=0 while resetn low, then 1; rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, mem_rd_en=0, mem_rd_addr=0.
//  States: IDLE, FETCH, WAIT, DATA.
//  - IDLE: arready=1. On arvalid&arready, latch id/addr/len/size/burst, clear beat_cnt, compute err, go to FETCH.
//  - FETCH: if err=0, assert mem_rd_en with mem_rd_addr=cur_addr. Go to WAIT.
//  - WAIT: capture rdata<=mem_rd_data (or 0 if err). Set rvalid=1, rresp=err?10:00, rlast=(beat_cnt==len). Go to DATA.
//  - DATA: hold rid/rdata/rresp/rlast/rvalid stable until rready.
//    On rvalid&rready with rlast: go to IDLE, rvalid=0.
//    Otherwise: beat_cnt++, cur_addr<=next_addr, rvalid=0, go to FETCH.
//  Throughput: 1 beat per 3 cycles with rready held high. rvalid rises 2 cycles after the AR handshake.
//  arready=0 in every state except IDLE, so only one burst is outstanding.
//  arready returns to 1 the cycle after the last R handshake.
//  Address arithmetic (bytes = 1<<size):
//  - FIXED: next = cur.
//  - INCR: next = (cur & ~(bytes-1)) + bytes, modulo 2^AW. First beat uses the unaligned araddr.
//  - WRAP: span = (len+1)*bytes; next = (cur & ~(span-1)) | ((cur + bytes) & (span-1)).
//  - No 4KB-boundary check; the master is responsible for that.
//  err=1 when any of the following holds. The full arlen+1 beats are still returned, with rresp=10 and rdata=0, and mem_rd_en is never asserted.
//  - size > log2(DW/8)
//  - burst=11
//  - WRAP with len not in {1,3,7,15}
//  - WRAP with araddr not aligned to size
//  err is burst-wide; there is no per-beat mixing of OKAY and SLVERR.
//  Simultaneous events: arvalid is ignored outside IDLE. An rready asserted while rvalid=0 has no effect.
//  Reset mid-operation: resetn low forces IDLE and clears rvalid/mem_rd_en immediately (asynchronous). The burst is discarded.
//  A pending mem_rd_data is ignored after reset.
//  arlen=0: single beat, rlast=1 on that beat.
// TESTING
//  1. INCR len=3 size=3 addr=0x100, rready=1 -> mem_rd_addr 0x100,0x108,0x110,0x118; rlast on beat 4 only; rresp=00.
//  2. WRAP len=3 size=3 addr=0x118 -> addrs 0x118,0x100,0x108,0x110; rlast on 4th; rid equals ARID=0xABC.
//  3. FIXED len=2 addr=0x40; then INCR size=0 addr=0x3 len=1 -> 0x40 x3; then 0x3,0x4.
//  4. rready low 5 cycles on beat 2 of INCR -> rdata/rlast/rresp stable, single mem_rd_en per beat, no beat lost.
//  5. size=4 (DW=64), len=1 -> 2 beats rresp=10, rdata=0, mem_rd_en never high; WRAP len=2 -> 3 SLVERR beats.
//  6. resetn low in DATA of beat 2 -> rvalid=0 same cycle; after release arready=1, new burst completes normally.

Source files
------------

// File: rtl/axi_read_slave_if.sv
// AXI4 read-channel bundle (AR + R) shared by the read master and the read slave.
// The slave modport is the responder view; the master modport drives requests.
interface axi_read_slave_if #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
);
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_slave.sv
// AXI4 read responder: accepts one AR burst at a time, walks FIXED/INCR/WRAP addresses,
// fetches each beat from a 1-cycle-latency memory port and returns it on R.
module axi_read_slave #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  axi_read_slave_if.slave      s_axi,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_rd_addr,
  input  logic [DW-1:0]        mem_rd_data
);

  localparam logic [2:0] SIZE_MAX    = 3'($clog2(DW / 8));
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DATA
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     beat_q, beat_d;
  logic [2:0]     size_q, size_d;
  logic [1:0]     burst_q, burst_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;
  logic           rlast_q, rlast_d;
  logic           rvalid_q, rvalid_d;
  logic           arready_q, arready_d;

  logic [AW-1:0]  bytes;
  logic [AW-1:0]  span;
  logic [AW-1:0]  next_addr;

  // A burst that fails any legality rule is still answered beat-for-beat, just never fetched.
  function automatic logic ar_err(input logic [AW-1:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] b;
    logic          e;
    b = AW'(1) << size;
    e = 1'b0;
    if (size > SIZE_MAX)      e = 1'b1;
    if (burst == 2'b11)       e = 1'b1;
    if (burst == BURST_WRAP) begin
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) e = 1'b1;
      if ((addr & (b - AW'(1))) != '0)             e = 1'b1;
    end
    return e;
  endfunction

  always_comb begin
    bytes = AW'(1) << size_q;
    span  = (AW'(len_q) + AW'(1)) << size_q;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_INCR:  next_addr = (addr_q & ~(bytes - AW'(1))) + bytes;
      BURST_WRAP:  next_addr = (addr_q & ~(span - AW'(1))) | ((addr_q + bytes) & (span - AW'(1)));
      default:     next_addr = addr_q;
    endcase
  end

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    size_d   = size_q;
    burst_d  = burst_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rvalid_d = rvalid_q;

    unique case (state_q)
      S_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          id_d    = s_axi.arid;
          addr_d  = s_axi.araddr;
          len_d   = s_axi.arlen;
          size_d  = s_axi.arsize;
          burst_d = s_axi.arburst;
          beat_d  = '0;
          err_d   = ar_err(s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst);
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        rdata_d  = err_q ? '0 : mem_rd_data;
        rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
        rlast_d  = (beat_q == len_q);
        rvalid_d = 1'b1;
        state_d  = S_DATA;
      end
      S_DATA: begin
        if (s_axi.rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so arready rises the cycle after the last R handshake.
    arready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  // Decoded from state so reset removes the strobe immediately.
  assign mem_rd_en     = (state_q == S_FETCH) && !err_q;
  assign mem_rd_addr   = mem_rd_en ? addr_q : '0;

  assign s_axi.arready = arready_q;
  assign s_axi.rid     = id_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: burst address walks, stalls, SLVERR bursts and mid-burst reset,
// against a 1-cycle-latency memory model whose word is {~addr, addr}.
module tb_axi_read_slave;

  localparam int IDW = 12;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic          clk;
  logic          resetn;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;

  axi_read_slave_if #(.IDW(IDW), .AW(AW), .DW(DW)) axi ();

  axi_read_slave #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_axi       (axi),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_addrs[$];
  logic [31:0] mon_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem_word(mem_rd_addr);
      mon_q.push_back(mem_rd_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_ar(input string name, input logic [11:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int cnt;
    @(negedge clk);
    axi.arid    = id;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = burst;
    axi.arvalid = 1'b1;
    cnt = 0;
    while (!axi.arready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({name, " arready"}, 64'(axi.arready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    axi.arvalid = 1'b0;
  endtask

  // Waits for rvalid from the first negedge after a handshake; expected latency is two cycles.
  task automatic wait_rvalid(input string tag);
    int cnt;
    cnt = 0;
    while (!axi.rvalid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " latency"}, 64'(cnt), 64'd2);
  endtask

  task automatic run_burst(input string name, input logic [11:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic err, input int stall_beat);
    logic [63:0] exp_data;
    int          n_fetch;
    mon_q.delete();
    issue_ar(name, id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      wait_rvalid($sformatf("%s b%0d", name, i));
      exp_data = 64'd0;
      if (!err) exp_data = mem_word(exp_addrs[i]);
      check($sformatf("%s b%0d rid", name, i),   64'(axi.rid),   64'(id));
      check($sformatf("%s b%0d rdata", name, i), axi.rdata,      exp_data);
      check($sformatf("%s b%0d rresp", name, i), 64'(axi.rresp), err ? 64'd2 : 64'd0);
      check($sformatf("%s b%0d rlast", name, i), 64'(axi.rlast), (i == int'(len)) ? 64'd1 : 64'd0);
      if (i == stall_beat) begin
        axi.rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check($sformatf("%s stall%0d rvalid", name, k), 64'(axi.rvalid), 64'd1);
          check($sformatf("%s stall%0d rdata", name, k),  axi.rdata,       exp_data);
          check($sformatf("%s stall%0d rlast", name, k),  64'(axi.rlast),  (i == int'(len)) ? 64'd1 : 64'd0);
          check($sformatf("%s stall%0d rresp", name, k),  64'(axi.rresp),  err ? 64'd2 : 64'd0);
          check($sformatf("%s stall%0d mem_rd_en", name, k), 64'(mem_rd_en), 64'd0);
        end
        axi.rready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check({name, " arready after last"}, 64'(axi.arready), 64'd1);
    check({name, " rvalid after last"},  64'(axi.rvalid),  64'd0);
    n_fetch = err ? 0 : int'(len) + 1;
    check({name, " fetch count"}, 64'(mon_q.size()), 64'(n_fetch));
    for (int i = 0; i < n_fetch && i < mon_q.size(); i++)
      check($sformatf("%s addr%0d", name, i), 64'(mon_q[i]), 64'(exp_addrs[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn      = 1'b0;
    axi.arid    = '0;
    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.arsize  = '0;
    axi.arburst = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    repeat (2) @(negedge clk);

    check("rst arready",     64'(axi.arready),  64'd0);
    check("rst rvalid",      64'(axi.rvalid),   64'd0);
    check("rst rlast",       64'(axi.rlast),    64'd0);
    check("rst rresp",       64'(axi.rresp),    64'd0);
    check("rst rid",         64'(axi.rid),      64'd0);
    check("rst rdata",       axi.rdata,         64'd0);
    check("rst mem_rd_en",   64'(mem_rd_en),    64'd0);
    check("rst mem_rd_addr", 64'(mem_rd_addr),  64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("post-rst arready", 64'(axi.arready), 64'd1);

    exp_addrs = '{32'h100, 32'h108, 32'h110, 32'h118};
    run_burst("incr", 12'h011, 32'h100, 8'd3, 3'd3, 2'b01, 1'b0, -1);

    exp_addrs = '{32'h118, 32'h100, 32'h108, 32'h110};
    run_burst("wrap", 12'hABC, 32'h118, 8'd3, 3'd3, 2'b10, 1'b0, -1);

    exp_addrs = '{32'h40, 32'h40, 32'h40};
    run_burst("fixed", 12'h022, 32'h40, 8'd2, 3'd3, 2'b00, 1'b0, -1);

    exp_addrs = '{32'h3, 32'h4};
    run_burst("incr8b", 12'h033, 32'h3, 8'd1, 3'd0, 2'b01, 1'b0, -1);

    exp_addrs = '{32'h105, 32'h108};
    run_burst("incr unaligned", 12'h044, 32'h105, 8'd1, 3'd3, 2'b01, 1'b0, -1);

    exp_addrs = '{32'h50};
    run_burst("single", 12'h055, 32'h50, 8'd0, 3'd3, 2'b01, 1'b0, -1);

    exp_addrs = '{32'h200, 32'h208, 32'h210, 32'h218};
    run_burst("stall", 12'h066, 32'h200, 8'd3, 3'd3, 2'b01, 1'b0, 1);

    exp_addrs = {};
    run_burst("err size", 12'h077, 32'h100, 8'd1, 3'd4, 2'b01, 1'b1, -1);
    run_burst("err wraplen", 12'h088, 32'h100, 8'd2, 3'd3, 2'b10, 1'b1, -1);
    run_burst("err burst11", 12'h099, 32'h100, 8'd0, 3'd3, 2'b11, 1'b1, -1);
    run_burst("err wrapalign", 12'h0AA, 32'h104, 8'd1, 3'd3, 2'b10, 1'b1, -1);

    // Reset while beat 2 is held in DATA.
    mon_q.delete();
    issue_ar("rstmid", 12'h0BB, 32'h400, 8'd3, 3'd3, 2'b01);
    wait_rvalid("rstmid b0");
    @(posedge clk);
    @(negedge clk);
    axi.rready = 1'b0;
    wait_rvalid("rstmid b1");
    check("rstmid rvalid before", 64'(axi.rvalid), 64'd1);
    resetn = 1'b0;
    #1;
    check("rstmid rvalid",    64'(axi.rvalid),  64'd0);
    check("rstmid mem_rd_en", 64'(mem_rd_en),   64'd0);
    check("rstmid arready",   64'(axi.arready), 64'd0);
    @(negedge clk);
    check("rstmid rvalid held", 64'(axi.rvalid), 64'd0);
    resetn     = 1'b1;
    axi.rready = 1'b1;
    @(negedge clk);
    check("rstmid arready release", 64'(axi.arready), 64'd1);

    exp_addrs = '{32'h300, 32'h308};
    run_burst("after reset", 12'h0CC, 32'h300, 8'd1, 3'd3, 2'b01, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
